// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter.
// Holds default sizes and the FSM state encoding.
package period_meter_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;

endpackage

// File: rtl/sync_edge.sv
// Synchronizer chain plus rise/fall pulse detector.
// Ports: clk, rst_n, sig_i (async in), rise_p/fall_p (1-cycle pulses).
module sync_edge
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_p,
  output logic fall_p
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   cur;

  assign cur = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= cur;
    end
  end

  assign rise_p = cur & ~prev_q;
  assign fall_p = ~cur & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of sig_in in prescaled ticks.
// Ports: clk, rst_n, en, prescaler, sig_in, ack_i in;
//        period_o, high_o, valid_o, ovf_o, overrun_o out.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] prescaler,
  input  logic             sig_in,
  input  logic             ack_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             overrun_o
);

  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic rise;
  logic fall;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (sig_in),
    .rise_p(rise),
    .fall_p(fall)
  );

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] psc_cnt_q, psc_cnt_d;
  logic [WIDTH-1:0] psc_lat_q, psc_lat_d;
  logic [WIDTH-1:0] tick_cnt_q, tick_cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             ovfo_q, ovfo_d;
  logic             overrun_q, overrun_d;

  logic             tick;
  logic             ack_hit;
  logic [WIDTH-1:0] cnt_sum;

  assign tick    = (psc_cnt_q == psc_lat_q);
  assign ack_hit = ack_i & valid_q;

  // Count value including a tick landing in this very cycle.
  assign cnt_sum = (tick && tick_cnt_q != ALL1)
                 ? tick_cnt_q + 1'b1 : tick_cnt_q;

  always_comb begin
    state_d    = state_q;
    psc_cnt_d  = psc_cnt_q;
    psc_lat_d  = psc_lat_q;
    tick_cnt_d = tick_cnt_q;
    ovf_d      = ovf_q;
    shadow_d   = shadow_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = valid_q;
    ovfo_d     = ovfo_q;
    overrun_d  = overrun_q;

    if (ack_hit) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (!en) begin
      state_d    = ST_IDLE;
      psc_cnt_d  = '0;
      tick_cnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_ARM;
          psc_cnt_d  = '0;
          tick_cnt_d = '0;
          ovf_d      = 1'b0;
        end
        ST_ARM, ST_MEAS: begin
          psc_cnt_d  = tick ? '0 : psc_cnt_q + 1'b1;
          tick_cnt_d = cnt_sum;
          if (cnt_sum == ALL1) ovf_d = 1'b1;
          if (rise) begin
            state_d    = ST_MEAS;
            psc_lat_d  = prescaler;
            psc_cnt_d  = '0;
            tick_cnt_d = '0;
            ovf_d      = 1'b0;
            // No falling edge before next rise leaves all-ones.
            shadow_d   = ALL1;
            if (state_q == ST_MEAS) begin
              period_d = cnt_sum;
              high_d   = shadow_q;
              ovfo_d   = ovf_q;
              valid_d  = 1'b1;
              if (valid_q && !ack_i) overrun_d = 1'b1;
            end
          end else if (fall && state_q == ST_MEAS) begin
            shadow_d = cnt_sum;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      psc_cnt_q  <= '0;
      psc_lat_q  <= '0;
      tick_cnt_q <= '0;
      ovf_q      <= 1'b0;
      shadow_q   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      ovfo_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      psc_cnt_q  <= psc_cnt_d;
      psc_lat_q  <= psc_lat_d;
      tick_cnt_q <= tick_cnt_d;
      ovf_q      <= ovf_d;
      shadow_q   <= shadow_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      ovfo_q     <= ovfo_d;
      overrun_q  <= overrun_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign ovf_o     = ovfo_q;
  assign overrun_o = overrun_q;

endmodule
